// File: rtl/cart_upload_responder.sv
// Serves HPS upload reads from cartridge RAM over the ioctl interface.
// One request at a time; the RAM port is shared with the CPU (mem_busy stalls the read).
module cart_upload_responder #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_upload,
  input  logic             ioctl_rd,
  input  logic [24:0]      ioctl_addr,
  output logic [7:0]       ioctl_din,
  output logic             ioctl_wait,
  input  logic [14:0]      cart_mask,
  input  logic             mem_busy,
  output logic             mem_rd,
  output logic [14:0]      mem_addr,
  input  logic [7:0]       mem_q,
  output logic             upload_active,
  output logic [CNT_W-1:0] upload_bytes
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LAT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]       LAT_LOAD  = 3'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] BYTES_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BYTES_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       lat_q, lat_d;
  logic [7:0]       din_q, din_d;
  logic             wait_q, wait_d;
  logic [14:0]      addr_q, addr_d;
  logic             active_q;
  logic [CNT_W-1:0] bytes_q, bytes_d;
  logic             mem_rd_s;
  logic             in_range_s;
  logic             upload_rise_s;

  // Request decode, next-state and counter logic.
  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    din_d         = din_q;
    wait_d        = wait_q;
    addr_d        = addr_q;
    bytes_d       = bytes_q;
    mem_rd_s      = 1'b0;
    in_range_s    = (ioctl_addr[24:15] == 10'd0) &&
                    ((ioctl_addr[14:0] & ~cart_mask) == 15'd0);
    upload_rise_s = ioctl_upload & ~active_q;

    case (state_q)
      S_IDLE: begin
        if (ioctl_rd && ioctl_upload) begin
          wait_d = 1'b1;
          if (in_range_s) begin
            addr_d  = ioctl_addr[14:0];
            state_d = S_ISSUE;
          end else begin
            din_d   = 8'hFF;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!ioctl_upload) begin
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!mem_busy) begin
          mem_rd_s = 1'b1;
          lat_d    = LAT_LOAD;
          state_d  = S_LAT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_LAT: begin
        if (!ioctl_upload) begin
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end else if (lat_q == 3'd0) begin
          din_d   = mem_q;
          wait_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_DONE: begin
        wait_d  = 1'b0;
        state_d = S_IDLE;
        // A dropped upload in this cycle counts as an abort, not a served byte.
        if (ioctl_upload && (bytes_q != BYTES_MAX)) begin
          bytes_d = bytes_q + BYTES_ONE;
        end else begin
          bytes_d = bytes_q;
        end
      end
      default: begin
        wait_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (upload_rise_s) begin
      bytes_d = {CNT_W{1'b0}};
    end else begin
      bytes_d = bytes_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lat_q    <= 3'd0;
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      addr_q   <= 15'd0;
      active_q <= 1'b0;
      bytes_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      active_q <= ioctl_upload;
      bytes_q  <= bytes_d;
    end
  end

  assign ioctl_din     = din_q;
  assign ioctl_wait    = wait_q;
  assign mem_rd        = mem_rd_s;
  assign mem_addr      = addr_q;
  assign upload_active = active_q;
  assign upload_bytes  = bytes_q;

endmodule

// File: tb/tb_cart_upload_responder.sv
// Directed bench for cart_upload_responder: one instance at RD_LATENCY=1, one at 3,
// each with its own RAM model that returns poison data unless sampled at the right latency.
module tb_cart_upload_responder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [14:0] cart_mask;
  logic        mem_busy;

  logic [7:0]  din_a, din_b;
  logic        wait_a, wait_b;
  logic        rd_a, rd_b;
  logic [14:0] addr_a, addr_b;
  logic [7:0]  q_a, q_b, p1_b, p2_b;
  logic        act_a, act_b;
  logic [15:0] bytes_a, bytes_b;

  logic [7:0]  ram [0:32767];
  logic [7:0]  exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  cart_upload_responder #(.RD_LATENCY(1), .CNT_W(16)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din_a), .ioctl_wait(wait_a), .cart_mask(cart_mask),
    .mem_busy(mem_busy), .mem_rd(rd_a), .mem_addr(addr_a), .mem_q(q_a),
    .upload_active(act_a), .upload_bytes(bytes_a)
  );

  cart_upload_responder #(.RD_LATENCY(3), .CNT_W(16)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din_b), .ioctl_wait(wait_b), .cart_mask(cart_mask),
    .mem_busy(mem_busy), .mem_rd(rd_b), .mem_addr(addr_b), .mem_q(q_b),
    .upload_active(act_b), .upload_bytes(bytes_b)
  );

  // Data is valid only at the nominal latency after a read strobe; otherwise 0xEE.
  always_ff @(posedge clk_sys) begin
    q_a  <= rd_a ? ram[addr_a] : 8'hEE;
    p1_b <= rd_b ? ram[addr_b] : 8'hEE;
    p2_b <= p1_b;
    q_b  <= p2_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Issue one request now, then follow it to completion, measuring strobe and wait timing.
  task automatic run_req(input string tag, input logic [24:0] addr, input logic [7:0] exp_din,
                         input int busy_n, input int exp_wait, input int exp_rd_at,
                         input bit use_b);
    int         wlen;
    int         rd_at;
    int         rd_cnt;
    bit         done;
    logic [7:0] e;
    exp_q.push_back(exp_din);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    tick();
    ioctl_rd = 1'b0;
    wlen = 0; rd_at = -1; rd_cnt = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      mem_busy = (c <= busy_n);
      #1;
      if (use_b ? rd_b : rd_a) begin
        rd_cnt++;
        if (rd_at < 0) rd_at = c;
        chk({tag, " mem_addr"}, 32'(use_b ? addr_b : addr_a), 32'(addr[14:0]));
      end
      if (use_b ? wait_b : wait_a) begin
        wlen++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    mem_busy = 1'b0;
    chk({tag, " completes"}, 32'(done), 32'd1);
    chk({tag, " wait cycles"}, 32'(wlen), 32'(exp_wait));
    chk({tag, " mem_rd cycle"}, 32'(rd_at), 32'(exp_rd_at));
    chk({tag, " mem_rd pulses"}, 32'(rd_cnt), (exp_rd_at < 0) ? 32'd0 : 32'd1);
    e = exp_q.pop_front();
    chk({tag, " ioctl_din"}, 32'(use_b ? din_b : din_a), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    ram[15'h0123] = 8'h5A;
    ram[15'h7FFF] = 8'hC3;
    ram[15'h0456] = 8'h77;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = 25'd0;
    cart_mask = 15'h0FFF; mem_busy = 1'b0;
    repeat (3) tick();
    #1;
    chk("reset din", 32'(din_a), 32'h00);
    chk("reset wait", 32'(wait_a), 32'd0);
    chk("reset mem_rd", 32'(rd_a), 32'd0);
    chk("reset mem_addr", 32'(addr_a), 32'd0);
    chk("reset active", 32'(act_a), 32'd0);
    chk("reset bytes", 32'(bytes_a), 32'd0);
    chk("reset b wait", 32'(wait_b), 32'd0);

    reset = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick(); tick(); #1;
    chk("active after raise", 32'(act_a), 32'd1);
    chk("bytes after raise", 32'(bytes_a), 32'd0);

    // Nominal read, then the same read with three busy cycles.
    run_req("t1", 25'h0000123, 8'h5A, 0, 2, 1, 1'b0);
    tick(); #1;
    chk("t1 bytes", 32'(bytes_a), 32'd1);
    run_req("t2", 25'h0000123, 8'h5A, 3, 5, 4, 1'b0);
    tick(); #1;
    chk("t2 bytes", 32'(bytes_a), 32'd2);

    ioctl_upload = 1'b0;
    tick(); tick(); #1;
    chk("active low", 32'(act_a), 32'd0);
    chk("bytes kept while low", 32'(bytes_a), 32'd2);
    ioctl_upload = 1'b1;
    tick(); tick(); #1;
    chk("bytes cleared on rise", 32'(bytes_a), 32'd0);

    // Out-of-range: beyond mask, and beyond 32 KiB.
    run_req("t3a", 25'h0001000, 8'hFF, 0, 1, -1, 1'b0);
    run_req("t3b", 25'h0008000, 8'hFF, 0, 1, -1, 1'b0);
    tick(); #1;
    chk("t3 bytes", 32'(bytes_a), 32'd2);

    // Three-cycle RAM latency on the second instance.
    cart_mask = 15'h7FFF;
    run_req("t4", 25'h0007FFF, 8'hC3, 0, 4, 1, 1'b1);
    tick(); tick(); #1;
    chk("t4 a din", 32'(din_a), 32'hC3);
    chk("t4 a bytes", 32'(bytes_a), 32'd3);

    // Upload dropped while waiting on RAM data.
    cart_mask  = 15'h0FFF;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h0000456;
    tick();
    ioctl_rd = 1'b0;
    #1;
    chk("t5 mem_rd", 32'(rd_a), 32'd1);
    tick();
    ioctl_upload = 1'b0;
    #1;
    chk("t5 wait in LAT", 32'(wait_a), 32'd1);
    tick(); #1;
    chk("t5 wait after abort", 32'(wait_a), 32'd0);
    chk("t5 din unchanged", 32'(din_a), 32'hC3);
    chk("t5 mem_rd after abort", 32'(rd_a), 32'd0);
    tick(); tick(); #1;
    chk("t5 bytes unchanged", 32'(bytes_a), 32'd3);
    chk("t5 active low", 32'(act_a), 32'd0);

    // Upload rises in the same cycle as a request: count restarts at 1.
    ioctl_upload = 1'b1;
    run_req("t5r", 25'h0000456, 8'h77, 0, 2, 1, 1'b0);
    tick(); #1;
    chk("t5r bytes", 32'(bytes_a), 32'd1);
    repeat (4) tick();

    // Reset while stalled in ISSUE.
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h0000123;
    tick();
    ioctl_rd = 1'b0;
    mem_busy = 1'b1;
    #1;
    chk("t6 stalled mem_rd", 32'(rd_a), 32'd0);
    chk("t6 stalled wait", 32'(wait_a), 32'd1);
    reset = 1'b1;
    tick();
    mem_busy = 1'b0;
    #1;
    chk("t6 reset din", 32'(din_a), 32'h00);
    chk("t6 reset wait", 32'(wait_a), 32'd0);
    chk("t6 reset mem_rd", 32'(rd_a), 32'd0);
    chk("t6 reset mem_addr", 32'(addr_a), 32'd0);
    chk("t6 reset active", 32'(act_a), 32'd0);
    chk("t6 reset bytes", 32'(bytes_a), 32'd0);
    reset = 1'b0;
    tick(); tick();
    run_req("t6", 25'h0000123, 8'h5A, 0, 2, 1, 1'b0);
    tick(); #1;
    chk("t6 bytes", 32'(bytes_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_upload_responder.md
Name: cart_upload_responder

Overview:
- Serves HPS upload (core-to-HPS readback) requests on the ioctl interface by reading bytes from cartridge RAM.
- Counterpart of the cartridge download path: the download path writes cart RAM from the HPS; this block reads cart RAM back to the HPS for ROM dump or save.
- Sits between hps_io (ioctl_upload/ioctl_rd/ioctl_din/ioctl_wait) and a shared cart RAM read port that the CPU may own in any cycle.

Parameters:
- RD_LATENCY, 1, cycles from the mem_rd cycle to mem_q valid (1..7).
- CNT_W, 16, width of the upload byte counter.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload session active.
- ioctl_rd  in  1  one-cycle read request strobe.
- ioctl_addr  in  25  byte address of the request.
- ioctl_din  out  8  returned byte (registered).
- ioctl_wait  out  1  high while a request is pending (registered).
- cart_mask  in  15  cart size mask (all-ones low bits).
- mem_busy  in  1  CPU owns the RAM port this cycle.
- mem_rd  out  1  RAM read strobe.
- mem_addr  out  15  RAM read address.
- mem_q  in  8  RAM read data.
- upload_active  out  1  registered copy of ioctl_upload.
- upload_bytes  out  CNT_W  bytes served this session, saturating.

Behaviour:
- One clock (clk_sys); reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - ioctl_din = 0, ioctl_wait = 0, mem_rd = 0, mem_addr = 0.
  - upload_active = 0, upload_bytes = 0.
- FSM states: IDLE, ISSUE, LAT, DONE.
- IDLE:
  - Accepts a request when ioctl_rd = 1 and ioctl_upload = 1 at edge T. Latch addr = ioctl_addr.
  - Next cycle ioctl_wait = 1.
  - In range when ioctl_addr[24:15] == 0 and (ioctl_addr[14:0] & ~cart_mask) == 0 → ISSUE.
  - Out of range → DONE with ioctl_din <= 8'hFF. Wait is high for exactly 1 cycle.
- ISSUE:
  - mem_addr = latched addr[14:0].
  - mem_rd = ~mem_busy (combinational from state). Stay in ISSUE while mem_busy = 1.
  - On the first cycle with mem_busy = 0, assert mem_rd for exactly 1 cycle, load the latency counter to RD_LATENCY-1, then go to LAT.
- LAT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_q into ioctl_din and go to DONE.
  - mem_q is sampled exactly RD_LATENCY cycles after the mem_rd cycle.
- DONE:
  - ioctl_wait = 0 from this cycle.
  - upload_bytes increments once, saturating at all-ones.
  - Back to IDLE the next cycle.
- Nominal timing (RD_LATENCY = 1, no busy): rd at T; wait high T+1..T+2; din valid and wait low at T+3. Each busy cycle adds 1.
- ioctl_din holds its value until the next completed request.
- ioctl_rd while not IDLE is ignored (protocol violation; no queuing). ioctl_rd with ioctl_upload = 0 is ignored.
- ioctl_upload falling while not IDLE: abort to IDLE next cycle, ioctl_wait = 0, mem_rd = 0, no count increment, ioctl_din unchanged.
- ioctl_upload rising edge: upload_bytes = 0.
- ioctl_upload rising together with ioctl_rd: the clear takes effect and the request is accepted; its completion counts as 1.
- mem_addr is held stable from ISSUE through DONE.
- Reset asserted mid-request forces the reset values on the next edge; an in-flight mem_q is discarded.

Test Plan:
1. cart_mask = 0x0FFF, RAM[0x0123] = 0x5A, rd at addr 0x123, mem_busy = 0 → mem_rd one cycle at T+1 with mem_addr = 0x123; ioctl_din = 0x5A and wait low at T+3; upload_bytes = 1.
2. Same request with mem_busy high for T+1..T+3 → mem_rd only at T+4; ioctl_din = 0x5A at T+6; wait high for 5 cycles.
3. cart_mask = 0x0FFF, addr 0x1000, then addr 0x8000 → no mem_rd; ioctl_din = 0xFF; wait high 1 cycle each; upload_bytes = 2.
4. RD_LATENCY = 3, RAM[0x7FFF] = 0xC3, cart_mask = 0x7FFF → mem_q sampled 3 cycles after mem_rd; ioctl_din = 0xC3 at T+5.
5. Drop ioctl_upload during LAT → wait low next cycle, upload_bytes unchanged, ioctl_din keeps its old value. Re-raise ioctl_upload → upload_bytes = 0.
6. Assert reset during ISSUE with mem_busy = 1 → next cycle all outputs 0, FSM IDLE; a fresh rd then completes normally.
